// File: rtl/jalr_resolve_pkg.sv
// -----------------------------------------------------------------------------
// jalr_resolve_pkg
// Shared types and constants for the JALR resolve block.
//   jalr_resolve_state_t : FSM state encoding (IDLE/WAIT/RESOLVE/FLUSH)
//   redirect_packet_t    : fetch redirect request {valid, pc}
//   JALR_TARGET_MASK     : clears bit 0 of rs1+imm to form the jump target
//   jalr_target()        : applies JALR_TARGET_MASK to a raw rs1+imm sum
// -----------------------------------------------------------------------------
package jalr_resolve_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2,
        FLUSH   = 2'd3
    } jalr_resolve_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redirect_packet_t;

    localparam logic [31:0] JALR_TARGET_MASK = 32'hFFFF_FFFE;

    function automatic logic [31:0] jalr_target(input logic [31:0] raw_addr);
        return raw_addr & JALR_TARGET_MASK;
    endfunction

endpackage

// File: rtl/jalr_resolve_if.sv
// -----------------------------------------------------------------------------
// jalr_resolve_if
// Bundles the ROB-head / JALR-queue inputs and the commit, redirect, flush and
// predictor-update outputs of the JALR resolve block.
//   modport slave  : the resolve block (consumes ROB/queue, drives results)
//   modport master : the surrounding pipeline (drives ROB/queue, sees results)
// -----------------------------------------------------------------------------
interface jalr_resolve_if;

    // ROB head and JALR queue head
    logic        rob_head_valid;
    logic        rob_head_is_jalr;
    logic [31:0] rob_head_pc;
    logic        jalrq_head_ready;
    logic [31:0] jalr_actual_address;
    logic [31:0] jalr_taken_address;

    // Resolution results
    logic        jalrq_rd_en;
    logic        commit_ok;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        pred_update_valid;
    logic [31:0] pred_update_pc;
    logic [31:0] pred_update_target;
    logic        busy;

    modport slave (
        input  rob_head_valid, rob_head_is_jalr, rob_head_pc,
        input  jalrq_head_ready, jalr_actual_address, jalr_taken_address,
        output jalrq_rd_en, commit_ok, redirect_valid, redirect_pc, flush,
        output pred_update_valid, pred_update_pc, pred_update_target, busy
    );

    modport master (
        output rob_head_valid, rob_head_is_jalr, rob_head_pc,
        output jalrq_head_ready, jalr_actual_address, jalr_taken_address,
        input  jalrq_rd_en, commit_ok, redirect_valid, redirect_pc, flush,
        input  pred_update_valid, pred_update_pc, pred_update_target, busy
    );

endinterface

// File: rtl/jalr_resolve_sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
// 32-bit event counter that sticks at 32'hFFFF_FFFF instead of wrapping.
//   clk     : system clock
//   reset   : asynchronous, active-high reset (count returns to 0)
//   en_i    : count one event this cycle
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/jalr_resolve.sv
// -----------------------------------------------------------------------------
// jalr_resolve
// Resolves the JALR at the ROB head: waits for its queue entry to be ready,
// compares the computed target with the fetch-time prediction, pops the queue,
// lets the ROB retire it, updates the predictor and, on a mispredict, redirects
// fetch and holds flush for FLUSH_CYCLES cycles (RESOLVE cycle included).
// Every output is a register; nothing flows combinationally from input to
// output.
//
// Parameters
//   FLUSH_CYCLES : cycles flush stays high per mispredict (1..15)
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   bus (slave)     : ROB/queue head in, commit/redirect/flush/predictor out
//   stat_resolved   : JALRs resolved (saturating)     [JALR_RESOLVE_STATS_EN]
//   stat_mispredict : JALRs mispredicted (saturating) [JALR_RESOLVE_STATS_EN]
// Configuration macro
//   JALR_RESOLVE_STATS_EN : adds the two statistics counters and their ports
// -----------------------------------------------------------------------------
module jalr_resolve
    import jalr_resolve_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    jalr_resolve_if.slave       bus
`ifdef JALR_RESOLVE_STATS_EN
    ,
    output logic [31:0]         stat_resolved,
    output logic [31:0]         stat_mispredict
`endif
);

    localparam logic [3:0] FLUSH_CNT_INIT  = 4'(FLUSH_CYCLES - 1);
    localparam logic       HAS_FLUSH_STATE = (FLUSH_CYCLES > 1);

    jalr_resolve_state_t state_q;
    logic [3:0]          flush_cnt_q;
    logic [31:0]         target_q;
    logic [31:0]         pc_q;
    logic                mispredict_q;
    redirect_packet_t    redirect_q;
    logic                pulse_q;   // shared by rd_en, commit_ok, pred update
    logic                flush_q;
    logic                busy_q;

    logic        head_jalr;
    logic        start;
    logic [31:0] target_in;
    logic        mispredict_in;

    assign head_jalr     = bus.rob_head_valid & bus.rob_head_is_jalr;
    assign start         = head_jalr & bus.jalrq_head_ready;
    assign target_in     = jalr_target(bus.jalr_actual_address);
    assign mispredict_in = (target_in != bus.jalr_taken_address);

    // Outputs are computed for the state being entered, so they appear in the
    // same cycle as the state itself.
    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_cnt_q  <= '0;
            target_q     <= '0;
            pc_q         <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            pulse_q      <= 1'b0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pulse_q          <= 1'b0;
            redirect_q.valid <= 1'b0;

            unique case (state_q)
                IDLE, WAIT: begin
                    if (start) begin
                        state_q      <= RESOLVE;
                        target_q     <= target_in;
                        pc_q         <= bus.rob_head_pc;
                        mispredict_q <= mispredict_in;
                        pulse_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        if (mispredict_in) begin
                            redirect_q.valid <= 1'b1;
                            redirect_q.pc    <= target_in;
                            flush_q          <= 1'b1;
                        end
                    end else if (head_jalr) begin
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                    end else begin
                        // Also covers a WAIT abort: no pop, no pulses.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                RESOLVE: begin
                    if (mispredict_q) begin
                        flush_cnt_q <= FLUSH_CNT_INIT;
                    end
                    if (mispredict_q && HAS_FLUSH_STATE) begin
                        state_q <= FLUSH;   // flush_q stays high
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        flush_q <= 1'b0;
                    end
                end

                FLUSH: begin
                    // ROB and queue inputs are deliberately ignored here.
                    flush_cnt_q <= flush_cnt_q - 4'd1;
                    if (flush_cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        flush_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.jalrq_rd_en        = pulse_q;
    assign bus.commit_ok          = pulse_q;
    assign bus.pred_update_valid  = pulse_q;
    assign bus.pred_update_pc     = pc_q;
    assign bus.pred_update_target = target_q;
    assign bus.redirect_valid     = redirect_q.valid;
    assign bus.redirect_pc        = redirect_q.pc;
    assign bus.flush              = flush_q;
    assign bus.busy               = busy_q;

`ifdef JALR_RESOLVE_STATS_EN
    // pulse_q is high exactly during RESOLVE, so each counter steps once per JALR.
    sat_counter32 u_stat_resolved (
        .clk     (clk),
        .reset   (reset),
        .en_i    (pulse_q),
        .count_o (stat_resolved)
    );

    sat_counter32 u_stat_mispredict (
        .clk     (clk),
        .reset   (reset),
        .en_i    (pulse_q & mispredict_q),
        .count_o (stat_mispredict)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_jalr_resolve.sv
// -----------------------------------------------------------------------------
// tb_jalr_resolve
// Self-checking bench for jalr_resolve (FLUSH_CYCLES = 3). A cycle-level
// behavioural model predicts every output; a compare process checks the DUT
// against it on every falling edge. Directed scenarios add literal checks,
// followed by a long randomized run with occasional asynchronous resets.
// Define JALR_RESOLVE_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_jalr_resolve;

    localparam int unsigned FLUSH_CYCLES = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    jalr_resolve_if bus ();

`ifdef JALR_RESOLVE_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    jalr_resolve #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef JALR_RESOLVE_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Describes the block as "a JALR is being resolved this cycle", "this many
    // flush cycles remain after this one" and "a JALR is waiting for its operand".
    bit          m_resolving;
    bit          m_mis;
    bit          m_waiting;
    int          m_flush_left;
    logic [31:0] m_target;
    logic [31:0] m_pc;
    logic [31:0] m_redirect_pc;
    int unsigned m_stat_res;
    int unsigned m_stat_mis;

    task automatic model_reset();
        m_resolving   = 1'b0;
        m_mis         = 1'b0;
        m_waiting     = 1'b0;
        m_flush_left  = 0;
        m_target      = '0;
        m_pc          = '0;
        m_redirect_pc = '0;
        m_stat_res    = 0;
        m_stat_mis    = 0;
    endtask

    task automatic model_step();
        bit          head;
        logic [31:0] tgt;
        head = bus.rob_head_valid && bus.rob_head_is_jalr;
        if (m_resolving) begin
            m_stat_res++;
            if (m_mis) m_stat_mis++;
            m_flush_left = m_mis ? int'(FLUSH_CYCLES) - 1 : 0;
            m_resolving  = 1'b0;
            m_waiting    = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (head && bus.jalrq_head_ready) begin
            // Target is rs1+imm rounded down to an even address.
            tgt         = bus.jalr_actual_address - (bus.jalr_actual_address % 32'd2);
            m_resolving = 1'b1;
            m_waiting   = 1'b0;
            m_target    = tgt;
            m_pc        = bus.rob_head_pc;
            m_mis       = (tgt != bus.jalr_taken_address);
            if (m_mis) m_redirect_pc = tgt;
        end else begin
            m_waiting = head;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("rd_en",          bus.jalrq_rd_en,       m_resolving);
            check("commit_ok",      bus.commit_ok,         m_resolving);
            check("pred_valid",     bus.pred_update_valid, m_resolving);
            check("redirect_valid", bus.redirect_valid,    m_resolving && m_mis);
            check("redirect_pc",    bus.redirect_pc,       m_redirect_pc);
            check("flush",          bus.flush,             (m_resolving && m_mis) || (m_flush_left > 0));
            check("busy",           bus.busy,              m_resolving || (m_flush_left > 0) || m_waiting);
            if (m_resolving) begin
                check("pred_pc",     bus.pred_update_pc,     m_pc);
                check("pred_target", bus.pred_update_target, m_target);
            end
`ifdef JALR_RESOLVE_STATS_EN
            check("stat_resolved",   stat_resolved,   m_stat_res);
            check("stat_mispredict", stat_mispredict, m_stat_mis);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_head(input logic v, input logic j, input logic rdy,
                            input logic [31:0] pc, input logic [31:0] act,
                            input logic [31:0] tak);
        bus.rob_head_valid      = v;
        bus.rob_head_is_jalr    = j;
        bus.jalrq_head_ready    = rdy;
        bus.rob_head_pc         = pc;
        bus.jalr_actual_address = act;
        bus.jalr_taken_address  = tak;
    endtask

    task automatic clear_head();
        set_head(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Presents one ready JALR, waits (bounded) for its dequeue and for the
    // block to go idle again.
    task automatic run_jalr(input logic [31:0] pc, input logic [31:0] act, input logic [31:0] tak);
        bit seen;
        bit idle;
        seen = 1'b0;
        idle = 1'b0;
        set_head(1'b1, 1'b1, 1'b1, pc, act, tak);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.jalrq_rd_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("run_jalr_resolved", seen, 1'b1);
        clear_head();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        check("run_jalr_idle", idle, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int flush_cnt;
        int rd_cnt;
        int rv_cnt;
        int pulses;
        bit busy_all;
        logic [31:0] act;
        logic [31:0] tak;

        clear_head();
        repeat (3) @(negedge clk);
        check("reset_flush", bus.flush, 1'b0);
        reset = 1'b0;

        // First cycle after release: everything low.
        @(negedge clk);
        check("post_reset_busy",        bus.busy, 1'b0);
        check("post_reset_redirect_pc", bus.redirect_pc, 32'h0);
        check("post_reset_rd_en",       bus.jalrq_rd_en, 1'b0);

        // Correct prediction: bit 0 of actual is dropped.
        set_head(1'b1, 1'b1, 1'b1, 32'h100, 32'h2001, 32'h2000);
        @(negedge clk);
        check("ok_rd_en",       bus.jalrq_rd_en, 1'b1);
        check("ok_commit",      bus.commit_ok, 1'b1);
        check("ok_pred_valid",  bus.pred_update_valid, 1'b1);
        check("ok_pred_target", bus.pred_update_target, 32'h2000);
        check("ok_pred_pc",     bus.pred_update_pc, 32'h100);
        check("ok_flush",       bus.flush, 1'b0);
        check("ok_redirect",    bus.redirect_valid, 1'b0);
        clear_head();
        @(negedge clk);
        check("ok_idle_after", bus.busy, 1'b0);

        // Mispredict: 3 flush cycles, one redirect, one pop.
        set_head(1'b1, 1'b1, 1'b1, 32'h200, 32'h3000, 32'h2000);
        @(negedge clk);
        check("mis_redirect_valid", bus.redirect_valid, 1'b1);
        check("mis_redirect_pc",    bus.redirect_pc, 32'h3000);
        flush_cnt = int'(bus.flush);
        rd_cnt    = int'(bus.jalrq_rd_en);
        rv_cnt    = 0;
        clear_head();
        repeat (6) begin
            @(negedge clk);
            flush_cnt += int'(bus.flush);
            rd_cnt    += int'(bus.jalrq_rd_en);
            rv_cnt    += int'(bus.redirect_valid);
        end
        check("mis_flush_cycles",  flush_cnt, 3);
        check("mis_rd_pulses",     rd_cnt, 1);
        check("mis_extra_redirect", rv_cnt, 0);
        check("mis_redirect_hold", bus.redirect_pc, 32'h3000);

        // Wait-then-ready.
        set_head(1'b1, 1'b1, 1'b0, 32'h300, 32'h4000, 32'h4000);
        pulses   = 0;
        busy_all = 1'b1;
        repeat (4) begin
            @(negedge clk);
            pulses  += int'(bus.jalrq_rd_en | bus.commit_ok | bus.pred_update_valid);
            busy_all = busy_all & bus.busy;
        end
        check("wait_busy",   busy_all, 1'b1);
        check("wait_pulses", pulses, 0);
        bus.jalrq_head_ready = 1'b1;
        @(negedge clk);
        check("wait_resolve_rd_en", bus.jalrq_rd_en, 1'b1);
        check("wait_resolve_busy",  bus.busy, 1'b1);
        clear_head();
        @(negedge clk);
        check("wait_done_busy", bus.busy, 1'b0);

        // Abort in WAIT.
        set_head(1'b1, 1'b1, 1'b0, 32'h400, 32'h5000, 32'h5000);
        @(negedge clk);
        check("abort_waiting", bus.busy, 1'b1);
        bus.rob_head_is_jalr = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(bus.jalrq_rd_en | bus.commit_ok);
        end
        check("abort_pulses", pulses, 0);
        check("abort_idle",   bus.busy, 1'b0);
        clear_head();

        // Async reset in the 2nd flush cycle.
        set_head(1'b1, 1'b1, 1'b1, 32'h500, 32'h7000, 32'h6000);
        @(negedge clk);
        check("rst_flush_1", bus.flush, 1'b1);
        clear_head();
        @(negedge clk);
        check("rst_flush_2", bus.flush, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rst_flush_drop", bus.flush, 1'b0);
        check("rst_busy_drop",  bus.busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_busy",        bus.busy, 1'b0);
        check("rst_after_redirect_pc", bus.redirect_pc, 32'h0);

        // 3 correct + 2 mispredicted after a clean reset.
        run_jalr(32'h1000, 32'h8001, 32'h8000);
        run_jalr(32'h1004, 32'h8100, 32'h8100);
        run_jalr(32'h1008, 32'h9000, 32'hA000);
        run_jalr(32'h100C, 32'h8201, 32'h8200);
        run_jalr(32'h1010, 32'hB003, 32'hB003);   // taken keeps bit 0: mismatch
`ifdef JALR_RESOLVE_STATS_EN
        check("stats_resolved_5",   stat_resolved, 32'd5);
        check("stats_mispredict_2", stat_mispredict, 32'd2);
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            act = $urandom;
            case ($urandom_range(0, 3))
                0:       tak = act - (act % 32'd2);
                1:       tak = act;
                2:       tak = $urandom;
                default: tak = (act - (act % 32'd2)) ^ (32'd1 << $urandom_range(1, 31));
            endcase
            set_head($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0, $urandom, act, tak);
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        clear_head();
        repeat (8) @(negedge clk);
        check("final_idle", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
